// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares one SDRAM controller burst port between the
// cache line-fill requester (port A, fixed priority) and the write-combining
// flush requester (port B). A starvation counter forces B in after a run of
// A grants, and each burst's fill strobes are routed only to the port that
// owns the controller.
module sdram_port_arbiter #(
    parameter int BURST_LEN    = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_req,
    input  logic [31:0] a_addr,
    input  logic        a_rw,
    input  logic [15:0] a_wdata,
    output logic        a_fill,
    output logic        a_grant,
    input  logic        b_req,
    input  logic [31:0] b_addr,
    input  logic        b_rw,
    input  logic [15:0] b_wdata,
    output logic        b_fill,
    output logic        b_grant,
    output logic        sdram_req,
    output logic [31:0] sdram_addr,
    output logic        sdram_rw,
    output logic [15:0] sdram_wdata,
    input  logic        sdram_fill,
    output logic        busy
);

    localparam int BEAT_W = (BURST_LEN < 2) ? 1 : $clog2(BURST_LEN + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        BURST   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                a_grant_q, a_grant_d;
    logic                b_grant_q, b_grant_d;
    logic                sdram_req_q, sdram_req_d;
    logic [31:0]         sdram_addr_q, sdram_addr_d;
    logic                sdram_rw_q, sdram_rw_d;
    logic [3:0]          starve_cnt_q, starve_cnt_d;
    logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;

    logic b_wins;
    logic a_wins;
    logic owner_req;
    logic fill_window;

    // The controller ignores the low address bits of a burst.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{a_addr[2:0], b_addr[2:0]};

    // B wins when A is absent or when A has starved it long enough.
    assign b_wins    = b_req && ((int'(starve_cnt_q) >= STARVE_LIMIT) || !a_req);
    assign a_wins    = a_req && !b_wins;
    assign owner_req = b_grant_q ? b_req : a_req;

    // Fill strobes only belong to a requester while its burst is in flight.
    assign fill_window = (state_q == ISSUE) || (state_q == BURST);

    assign a_fill      = sdram_fill & a_grant_q & fill_window;
    assign b_fill      = sdram_fill & b_grant_q & fill_window;
    assign a_grant     = a_grant_q;
    assign b_grant     = b_grant_q;
    assign busy        = a_grant_q | b_grant_q;
    assign sdram_req   = sdram_req_q;
    assign sdram_addr  = sdram_addr_q;
    assign sdram_rw    = sdram_rw_q;
    assign sdram_wdata = b_grant_q ? b_wdata : a_wdata;

    // Next-state logic: arbitration, burst beat tracking and release handshake.
    always_comb begin
        state_d      = state_q;
        a_grant_d    = a_grant_q;
        b_grant_d    = b_grant_q;
        sdram_req_d  = sdram_req_q;
        sdram_addr_d = sdram_addr_q;
        sdram_rw_d   = sdram_rw_q;
        starve_cnt_d = starve_cnt_q;
        beat_cnt_d   = beat_cnt_q;

        case (state_q)
            IDLE: begin
                if (b_wins) begin
                    b_grant_d    = 1'b1;
                    sdram_req_d  = 1'b1;
                    sdram_addr_d = {b_addr[31:3], 3'b000};
                    sdram_rw_d   = b_rw;
                    starve_cnt_d = 4'd0;
                    state_d      = ISSUE;
                end else if (a_wins) begin
                    a_grant_d    = 1'b1;
                    sdram_req_d  = 1'b1;
                    sdram_addr_d = {a_addr[31:3], 3'b000};
                    sdram_rw_d   = a_rw;
                    if (b_req && (starve_cnt_q != 4'd15)) begin
                        starve_cnt_d = starve_cnt_q + 4'd1;
                    end
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                // The first fill beat acknowledges the request.
                if (sdram_fill) begin
                    sdram_req_d = 1'b0;
                    beat_cnt_d  = BEAT_W'(1);
                    state_d     = (BURST_LEN == 1) ? RELEASE : BURST;
                end
            end
            BURST: begin
                // Gaps in sdram_fill simply hold the beat count.
                if (sdram_fill) begin
                    beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                    if (beat_cnt_q == BEAT_W'(BURST_LEN - 1)) begin
                        state_d = RELEASE;
                    end
                end
            end
            RELEASE: begin
                // Hold ownership until the requester acknowledges completion.
                if (!owner_req) begin
                    a_grant_d  = 1'b0;
                    b_grant_d  = 1'b0;
                    beat_cnt_d = '0;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous reset; reset abandons any burst in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            a_grant_q    <= 1'b0;
            b_grant_q    <= 1'b0;
            sdram_req_q  <= 1'b0;
            sdram_addr_q <= 32'd0;
            sdram_rw_q   <= 1'b1;
            starve_cnt_q <= 4'd0;
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            a_grant_q    <= a_grant_d;
            b_grant_q    <= b_grant_d;
            sdram_req_q  <= sdram_req_d;
            sdram_addr_q <= sdram_addr_d;
            sdram_rw_q   <= sdram_rw_d;
            starve_cnt_q <= starve_cnt_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

endmodule
